// File: rtl/overcurrent_monitor.sv
// Overcurrent monitor: two independent channels that each synchronize a raw comparator input,
// debounce it into a fault flag, gate the motor enable, and run a trip / cooldown / auto-retry
// sequence that escalates to a latched lockout cleared only by an operator pulse.
module overcurrent_monitor #(
  parameter int unsigned DEBOUNCE     = 1000,
  parameter int unsigned COOLDOWN     = 50_000_000,
  parameter int unsigned CLEAR_WINDOW = 100_000_000,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned CW           = 27
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cur_a_raw,
  input  logic       cur_b_raw,
  input  logic       fault_clear,
  output logic       SensorA,
  output logic       SensorB,
  output logic       motor_en_a,
  output logic       motor_en_b,
  output logic       lockout_a,
  output logic       lockout_b,
  output logic [3:0] retry_cnt_a,
  output logic [3:0] retry_cnt_b
);

  typedef enum logic [1:0] {StRun = 2'd0, StCool = 2'd1, StLock = 2'd2} state_e;

  // Terminal counts, pre-truncated to the shared counter width.
  localparam logic [CW-1:0] DebLast  = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CoolLast = CW'(COOLDOWN - 1);
  localparam logic [CW-1:0] ClrLast  = CW'(CLEAR_WINDOW - 1);
  localparam logic [3:0]    RetryMax = 4'(MAX_RETRY);

  logic [1:0] raw;
  logic [1:0] sensor;
  logic [1:0] motor_en;
  logic [1:0] lockout;
  logic [3:0] retry_cnt [2];

  assign raw = {cur_b_raw, cur_a_raw};

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic          sync1_q, s_q;
    state_e        state_q, state_d;
    logic [CW-1:0] deb_q, deb_d;
    logic [CW-1:0] clr_q, clr_d;
    logic [CW-1:0] tmr_q, tmr_d;
    logic [3:0]    retry_q, retry_d, retry_inc;
    logic          sensor_q, sensor_d;
    logic          motor_en_q, motor_en_d;
    logic          lockout_q, lockout_d;

    // Two-flop synchronizer for the asynchronous comparator input.
    always_ff @(posedge clock) begin
      if (reset) begin
        sync1_q <= 1'b0;
        s_q     <= 1'b0;
      end else begin
        sync1_q <= raw[c];
        s_q     <= sync1_q;
      end
    end

    // State register and per-channel counters.
    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= StRun;
        deb_q   <= '0;
        clr_q   <= '0;
        tmr_q   <= '0;
        retry_q <= '0;
      end else begin
        state_q <= state_d;
        deb_q   <= deb_d;
        clr_q   <= clr_d;
        tmr_q   <= tmr_d;
        retry_q <= retry_d;
      end
    end

    // Next-state and counter update logic.
    always_comb begin
      state_d   = state_q;
      deb_d     = deb_q;
      clr_d     = clr_q;
      tmr_d     = tmr_q;
      retry_d   = retry_q;
      retry_inc = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;
      unique case (state_q)
        StRun: begin
          if (s_q) begin
            clr_d = '0;
            if (deb_q == DebLast) begin
              // Trip: increments from the pre-clear value, so it beats the clear window.
              retry_d = retry_inc;
              deb_d   = '0;
              tmr_d   = '0;
              state_d = (retry_inc >= RetryMax) ? StLock : StCool;
            end else begin
              deb_d = deb_q + 1'b1;
            end
          end else begin
            deb_d = '0;
            if (clr_q == ClrLast) begin
              retry_d = '0;
            end else begin
              clr_d = clr_q + 1'b1;
            end
          end
        end
        StCool: begin
          if (fault_clear) begin
            // Operator clear wins over a coincident cooldown timeout.
            state_d = StRun;
            retry_d = '0;
            deb_d   = '0;
            clr_d   = '0;
          end else if (tmr_q == CoolLast) begin
            state_d = StRun;
            deb_d   = '0;
            clr_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        StLock: begin
          if (fault_clear) begin
            state_d = StRun;
            retry_d = '0;
            deb_d   = '0;
            clr_d   = '0;
          end
        end
        default: begin
          state_d = StRun;
        end
      endcase
    end

    // Output decode from the next state so the registered flags change on the transition edge.
    always_comb begin
      sensor_d   = (state_d != StRun);
      motor_en_d = (state_d == StRun);
      lockout_d  = (state_d == StLock);
    end

    // Output registers; all held low during reset so the enable rises one cycle after release.
    always_ff @(posedge clock) begin
      if (reset) begin
        sensor_q   <= 1'b0;
        motor_en_q <= 1'b0;
        lockout_q  <= 1'b0;
      end else begin
        sensor_q   <= sensor_d;
        motor_en_q <= motor_en_d;
        lockout_q  <= lockout_d;
      end
    end

    assign sensor[c]    = sensor_q;
    assign motor_en[c]  = motor_en_q;
    assign lockout[c]   = lockout_q;
    assign retry_cnt[c] = retry_q;
  end

  assign SensorA     = sensor[0];
  assign SensorB     = sensor[1];
  assign motor_en_a  = motor_en[0];
  assign motor_en_b  = motor_en[1];
  assign lockout_a   = lockout[0];
  assign lockout_b   = lockout[1];
  assign retry_cnt_a = retry_cnt[0];
  assign retry_cnt_b = retry_cnt[1];

endmodule

// File: tb/tb_overcurrent_monitor.sv
// Self-checking bench for overcurrent_monitor: directed scenarios plus randomized traffic,
// compared against a streak-counting behavioural model of each channel.
module tb_overcurrent_monitor;

  localparam int DEB   = 4;
  localparam int COOL  = 8;
  localparam int CLRW  = 16;
  localparam int MAXR  = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cur_a_raw = 1'b0;
  logic       cur_b_raw = 1'b0;
  logic       fault_clear = 1'b0;
  logic       SensorA, SensorB, motor_en_a, motor_en_b, lockout_a, lockout_b;
  logic [3:0] retry_cnt_a, retry_cnt_b;

  int checks = 0;
  int errors = 0;

  overcurrent_monitor #(
    .DEBOUNCE    (DEB),
    .COOLDOWN    (COOL),
    .CLEAR_WINDOW(CLRW),
    .MAX_RETRY   (MAXR),
    .CW          (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cur_a_raw  (cur_a_raw),
    .cur_b_raw  (cur_b_raw),
    .fault_clear(fault_clear),
    .SensorA    (SensorA),
    .SensorB    (SensorB),
    .motor_en_a (motor_en_a),
    .motor_en_b (motor_en_b),
    .lockout_a  (lockout_a),
    .lockout_b  (lockout_b),
    .retry_cnt_a(retry_cnt_a),
    .retry_cnt_b(retry_cnt_b)
  );

  always #5 clock = ~clock;

  logic [13:0] obs;
  assign obs = {SensorA, SensorB, motor_en_a, motor_en_b, lockout_a, lockout_b,
                retry_cnt_a, retry_cnt_b};

  // Behavioural model: mode 0 = running, 1 = cooling down, 2 = locked out.
  int m_mode  [2];
  int m_hi    [2];  // consecutive synchronized-high cycles while running
  int m_quiet [2];  // consecutive synchronized-low cycles while running
  int m_cool  [2];  // cycles spent cooling down
  int m_retry [2];
  bit m_pipe1 [2];
  bit m_sync  [2];
  bit m_zero;       // outputs forced low by reset on the last edge

  task automatic model_edge();
    bit rawv [2];
    rawv[0] = cur_a_raw;
    rawv[1] = cur_b_raw;
    if (reset) begin
      m_zero = 1'b1;
      for (int c = 0; c < 2; c++) begin
        m_mode[c] = 0; m_hi[c] = 0; m_quiet[c] = 0; m_cool[c] = 0; m_retry[c] = 0;
        m_pipe1[c] = 1'b0; m_sync[c] = 1'b0;
      end
    end else begin
      m_zero = 1'b0;
      for (int c = 0; c < 2; c++) begin
        if (m_mode[c] == 0) begin
          if (m_sync[c]) begin
            m_quiet[c] = 0;
            m_hi[c]++;
            if (m_hi[c] == DEB) begin
              m_retry[c] = (m_retry[c] + 1 > 15) ? 15 : m_retry[c] + 1;
              m_hi[c]    = 0;
              m_cool[c]  = 0;
              m_mode[c]  = (m_retry[c] >= MAXR) ? 2 : 1;
            end
          end else begin
            m_hi[c] = 0;
            m_quiet[c]++;
            if (m_quiet[c] >= CLRW) m_retry[c] = 0;
          end
        end else if (fault_clear) begin
          m_mode[c] = 0; m_hi[c] = 0; m_quiet[c] = 0; m_retry[c] = 0;
        end else if (m_mode[c] == 1) begin
          m_cool[c]++;
          if (m_cool[c] == COOL) begin
            m_mode[c] = 0; m_hi[c] = 0; m_quiet[c] = 0;
          end
        end
        m_sync[c]  = m_pipe1[c];
        m_pipe1[c] = rawv[c];
      end
    end
  endtask

  function automatic logic [13:0] exp_vec();
    logic [13:0] v;
    v = '0;
    if (!m_zero) begin
      v[13] = (m_mode[0] != 0);
      v[12] = (m_mode[1] != 0);
      v[11] = (m_mode[0] == 0);
      v[10] = (m_mode[1] == 0);
      v[9]  = (m_mode[0] == 2);
      v[8]  = (m_mode[1] == 2);
    end
    v[7:4] = 4'(m_retry[0]);
    v[3:0] = 4'(m_retry[1]);
    return v;
  endfunction

  // Advance one clock, step the model with the inputs seen at that edge, then settle.
  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 14'h0) begin
        errors++;
        $display("FAIL reset_outputs: got %h expected %h", obs, 14'h0);
      end
    end
    reset = 1'b0;
    tick();
    checks++;
    if (motor_en_a !== 1'b1 || motor_en_b !== 1'b1 || SensorA !== 1'b0 || SensorB !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got en=%b%b sensor=%b%b expected en=11 sensor=00",
               motor_en_a, motor_en_b, SensorA, SensorB);
    end
  endtask

  task automatic test_glitch_and_trip();
    int n = 0;
    cur_a_raw = 1'b1;
    repeat (3) tick();
    cur_a_raw = 1'b0;
    repeat (6) tick();
    checks++;
    if (SensorA !== 1'b0 || retry_cnt_a !== 4'd0) begin
      errors++;
      $display("FAIL glitch_no_trip: got sensor=%b retry=%0d expected sensor=0 retry=0",
               SensorA, retry_cnt_a);
    end
    cur_a_raw = 1'b1;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      tick();
      if (SensorA === 1'b1) n = i;
    end
    checks++;
    if (n != DEB + 2) begin
      errors++;
      $display("FAIL trip_latency: got %0d cycles expected %0d", n, DEB + 2);
    end
    checks++;
    if (motor_en_a !== 1'b0 || retry_cnt_a !== 4'd1) begin
      errors++;
      $display("FAIL trip_state: got en=%b retry=%0d expected en=0 retry=1",
               motor_en_a, retry_cnt_a);
    end
    checks++;
    if (SensorB !== 1'b0 || motor_en_b !== 1'b1 || retry_cnt_b !== 4'd0) begin
      errors++;
      $display("FAIL chan_b_isolated: got sensor=%b en=%b retry=%0d expected 0 1 0",
               SensorB, motor_en_b, retry_cnt_b);
    end
  endtask

  task automatic test_cooldown_and_clear_window();
    int n = 0;
    cur_a_raw = 1'b0;
    for (int i = 1; i <= 30 && n == 0; i++) begin
      tick();
      if (SensorA === 1'b0) n = i;
    end
    checks++;
    if (n != COOL || motor_en_a !== 1'b1) begin
      errors++;
      $display("FAIL cooldown_len: got %0d cycles en=%b expected %0d cycles en=1",
               n, motor_en_a, COOL);
    end
    repeat (CLRW - 1) tick();
    checks++;
    if (retry_cnt_a !== 4'd1) begin
      errors++;
      $display("FAIL clear_window_early: got %0d expected 1", retry_cnt_a);
    end
    tick();
    checks++;
    if (retry_cnt_a !== 4'd0) begin
      errors++;
      $display("FAIL clear_window: got %0d expected 0", retry_cnt_a);
    end
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL model_after_cooldown: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_lockout();
    int n = 0;
    int bad = 0;
    cur_b_raw = 1'b1;
    for (int i = 1; i <= 60 && n == 0; i++) begin
      tick();
      if (lockout_b === 1'b1) n = i;
    end
    checks++;
    if (n != 2 * DEB + 2 + COOL || retry_cnt_b !== 4'd2) begin
      errors++;
      $display("FAIL lockout_entry: got %0d cycles retry=%0d expected %0d cycles retry=2",
               n, retry_cnt_b, 2 * DEB + 2 + COOL);
    end
    cur_b_raw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (SensorB !== 1'b1 || motor_en_b !== 1'b0 || lockout_b !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL lockout_hold: got %0d bad cycles expected 0", bad);
    end
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    checks++;
    if (lockout_b !== 1'b0 || SensorB !== 1'b0 || motor_en_b !== 1'b1 || retry_cnt_b !== 4'd0) begin
      errors++;
      $display("FAIL lockout_clear: got lock=%b sensor=%b en=%b retry=%0d expected 0 0 1 0",
               lockout_b, SensorB, motor_en_b, retry_cnt_b);
    end
  endtask

  task automatic test_simultaneous();
    int n = 0;
    cur_a_raw = 1'b1;
    cur_b_raw = 1'b1;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      tick();
      if (SensorA === 1'b1 || SensorB === 1'b1) n = i;
    end
    checks++;
    if (n != DEB + 2 || SensorA !== 1'b1 || SensorB !== 1'b1) begin
      errors++;
      $display("FAIL both_trip: got %0d cycles sensors=%b%b expected %0d cycles sensors=11",
               n, SensorA, SensorB, DEB + 2);
    end
    cur_a_raw = 1'b0;
    cur_b_raw = 1'b0;
    repeat (COOL - 1) tick();
    checks++;
    if (SensorA !== 1'b1) begin
      errors++;
      $display("FAIL cool_before_timeout: got %b expected 1", SensorA);
    end
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    checks++;
    if (SensorA !== 1'b0 || motor_en_a !== 1'b1 || retry_cnt_a !== 4'd0) begin
      errors++;
      $display("FAIL clear_vs_timeout: got sensor=%b en=%b retry=%0d expected 0 1 0",
               SensorA, motor_en_a, retry_cnt_a);
    end
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL model_after_simultaneous: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_reset_in_lock();
    int n = 0;
    cur_a_raw = 1'b1;
    for (int i = 1; i <= 60 && n == 0; i++) begin
      tick();
      if (lockout_a === 1'b1) n = i;
    end
    checks++;
    if (n == 0) begin
      errors++;
      $display("FAIL reach_lock_a: got no lockout expected lockout_a=1");
    end
    reset = 1'b1;
    cur_a_raw = 1'b0;
    tick();
    checks++;
    if (lockout_a !== 1'b0 || SensorA !== 1'b0 || retry_cnt_a !== 4'd0) begin
      errors++;
      $display("FAIL reset_in_lock: got lock=%b sensor=%b retry=%0d expected 0 0 0",
               lockout_a, SensorA, retry_cnt_a);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (motor_en_a !== 1'b1 || SensorA !== 1'b0) begin
      errors++;
      $display("FAIL release_after_lock: got en=%b sensor=%b expected en=1 sensor=0",
               motor_en_a, SensorA);
    end
  endtask

  task automatic test_random();
    int seg_a = 0;
    int seg_b = 0;
    int bad   = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg_a == 0) begin
        cur_a_raw = ($urandom_range(0, 2) != 0);
        seg_a = $urandom_range(1, 12);
      end
      if (seg_b == 0) begin
        cur_b_raw = ($urandom_range(0, 2) != 0);
        seg_b = $urandom_range(1, 12);
      end
      seg_a--;
      seg_b--;
      fault_clear = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        if (bad < 10) $display("FAIL random_cycle_%0d: got %h expected %h", i, obs, exp_vec());
        bad++;
      end
    end
    reset = 1'b0;
    fault_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch_and_trip();
    test_cooldown_and_clear_window();
    test_lockout();
    test_simultaneous();
    test_reset_in_lock();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
